rob_recovery_ctrl: RTL and testbench

//  Sequences machine recovery when the ROB head entry retires as a mispredicted branch/jump.

---
 rtl/rob_recovery_ctrl_pkg.sv | 25 ++
 rtl/rob_recovery_ctrl_if.sv | 32 +++
 rtl/rob_recovery_ctrl_sat_counter.sv | 23 ++
 rtl/rob_recovery_ctrl.sv | 113 +++++++++++
 tb/tb_rob_recovery_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared ROB/fetch types and sizes: recovery FSM state encoding, PC and
// architectural-register index widths, drain timeout.
package rob_pkg;

  localparam int PC_W      = 16;
  localparam int ARF_REGS  = 8;
  localparam int ARF_IDX_W = $clog2(ARF_REGS);

  localparam int                     DRAIN_CNT_W   = 8;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_TIMEOUT = 8'd255;

  localparam int REC_CNT_W = 16;

  localparam logic [ARF_IDX_W-1:0] LAST_RESTORE_IDX = ARF_IDX_W'(ARF_REGS - 1);

  // One-hot so every output decode is a single flop bit.
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    FLUSH    = 5'b00010,
    DRAIN    = 5'b00100,
    RESTORE  = 5'b01000,
    REDIRECT = 5'b10000
  } rec_state_t;

endpackage

// File: rtl/rob_recovery_ctrl_if.sv
// Recovery controller bundle: ROB head / store buffer / fetch inputs and the
// flush, RAT restore and redirect outputs.
interface rob_recovery_ctrl_if;
  import rob_pkg::*;

  logic                 Head_Mispred;
  logic [PC_W-1:0]      Head_Correct_PC;
  logic                 SB_Commit_Empty;
  logic                 Redirect_Ack;
  logic                 Global_Flush;
  logic                 Rec_Busy;
  logic                 RAT_Restore_V;
  logic [ARF_IDX_W-1:0] RAT_Restore_Idx;
  logic                 Redirect_V;
  logic [PC_W-1:0]      Redirect_PC;
  logic                 Drain_Err;
  logic [REC_CNT_W-1:0] Recovery_Cnt;

  // master: the recovery controller; slave: ROB, store buffer, RAT and fetch.
  modport master (
    input  Head_Mispred, Head_Correct_PC, SB_Commit_Empty, Redirect_Ack,
    output Global_Flush, Rec_Busy, RAT_Restore_V, RAT_Restore_Idx,
           Redirect_V, Redirect_PC, Drain_Err, Recovery_Cnt
  );

  modport slave (
    output Head_Mispred, Head_Correct_PC, SB_Commit_Empty, Redirect_Ack,
    input  Global_Flush, Rec_Busy, RAT_Restore_V, RAT_Restore_Idx,
           Redirect_V, Redirect_PC, Drain_Err, Recovery_Cnt
  );

endinterface

// File: rtl/rob_recovery_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Mispredict recovery sequencer: flush, drain committed stores, restore the RAT
// one architectural register per cycle, then redirect fetch with a handshake.
module rob_recovery_ctrl
  import rob_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  rob_recovery_ctrl_if.master bus
);

  rec_state_t             state_reg;
  logic [DRAIN_CNT_W-1:0] drain_cnt_reg;
  logic [DRAIN_CNT_W-1:0] drain_cnt_next;
  logic [ARF_IDX_W-1:0]   restore_idx_reg;
  logic [PC_W-1:0]        redirect_pc_reg;
  logic                   drain_err_reg;
  logic                   flush_reg;
  logic                   busy_reg;
  logic                   restore_v_reg;
  logic                   redirect_v_reg;
  logic                   rec_done;

  assign drain_cnt_next = drain_cnt_reg + DRAIN_CNT_W'(1);

  // Outputs are flops updated on the same transitions as the state register,
  // so nothing combinational reaches the ports from the inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE;
      drain_cnt_reg   <= '0;
      restore_idx_reg <= '0;
      redirect_pc_reg <= '0;
      drain_err_reg   <= 1'b0;
      flush_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      restore_v_reg   <= 1'b0;
      redirect_v_reg  <= 1'b0;
    end else begin
      flush_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.Head_Mispred) begin
            state_reg       <= FLUSH;
            redirect_pc_reg <= bus.Head_Correct_PC;
            flush_reg       <= 1'b1;
            busy_reg        <= 1'b1;
          end
        end
        FLUSH: begin
          state_reg     <= DRAIN;
          drain_cnt_reg <= '0;
        end
        DRAIN: begin
          if (bus.SB_Commit_Empty) begin
            state_reg     <= RESTORE;
            restore_v_reg <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_next;
            // Stuck store buffer: give up, flag it, and restore anyway.
            if (drain_cnt_next == DRAIN_TIMEOUT) begin
              drain_err_reg <= 1'b1;
              state_reg     <= RESTORE;
              restore_v_reg <= 1'b1;
            end
          end
        end
        RESTORE: begin
          // Index wraps to 0 naturally after the last register.
          restore_idx_reg <= restore_idx_reg + ARF_IDX_W'(1);
          if (restore_idx_reg == LAST_RESTORE_IDX) begin
            state_reg      <= REDIRECT;
            restore_v_reg  <= 1'b0;
            redirect_v_reg <= 1'b1;
          end
        end
        REDIRECT: begin
          if (bus.Redirect_Ack) begin
            state_reg      <= IDLE;
            redirect_v_reg <= 1'b0;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          restore_idx_reg <= '0;
          busy_reg        <= 1'b0;
          restore_v_reg   <= 1'b0;
          redirect_v_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rec_done = redirect_v_reg & bus.Redirect_Ack;

  sat_counter #(
    .W (REC_CNT_W)
  ) u_rec_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (rec_done),
    .count (bus.Recovery_Cnt)
  );

  assign bus.Global_Flush    = flush_reg;
  assign bus.Rec_Busy        = busy_reg;
  assign bus.RAT_Restore_V   = restore_v_reg;
  assign bus.RAT_Restore_Idx = restore_idx_reg;
  assign bus.Redirect_V      = redirect_v_reg;
  assign bus.Redirect_PC     = redirect_pc_reg;
  assign bus.Drain_Err       = drain_err_reg;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl: normal recovery, delayed drain, drain
// timeout, delayed ack, async reset mid-restore, back-to-back recoveries.
module tb_rob_recovery_ctrl;
  import rob_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rob_recovery_ctrl_if bus_if ();

  rob_recovery_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Called in the FLUSH cycle. SB_Commit_Empty is raised in DRAIN cycle
  // release_at (0 = never). Returns at the first RESTORE cycle.
  task automatic drain_phase(input int release_at, output int cycles, output logic err_early);
    cycles    = 0;
    err_early = 1'b0;
    cyc();
    while (!bus_if.RAT_Restore_V && cycles < 300) begin
      cycles++;
      if (bus_if.Drain_Err) err_early = 1'b1;
      if (cycles == release_at) bus_if.SB_Commit_Empty = 1'b1;
      cyc();
    end
  endtask

  // Called in the first RESTORE cycle; returns in the first REDIRECT cycle.
  task automatic expect_restore(input string tag);
    for (int i = 0; i < ARF_REGS; i++) begin
      check({tag, "_rat_v"}, 32'(bus_if.RAT_Restore_V), 32'd1);
      check({tag, "_rat_idx"}, 32'(bus_if.RAT_Restore_Idx), 32'(i));
      cyc();
    end
    check({tag, "_redir_v"}, 32'(bus_if.Redirect_V), 32'd1);
    check({tag, "_rat_v_off"}, 32'(bus_if.RAT_Restore_V), 32'd0);
    check({tag, "_idx_wrap"}, 32'(bus_if.RAT_Restore_Idx), 32'd0);
  endtask

  task automatic start_seq(input logic [15:0] pc, input logic sb_empty);
    bus_if.Head_Mispred    = 1'b1;
    bus_if.Head_Correct_PC = pc;
    bus_if.SB_Commit_Empty = sb_empty;
    cyc();
    bus_if.Head_Mispred = 1'b0;
  endtask

  int   dcyc;
  logic derr;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst                    = 1'b1;
    bus_if.Head_Mispred    = 1'b0;
    bus_if.Head_Correct_PC = '0;
    bus_if.SB_Commit_Empty = 1'b0;
    bus_if.Redirect_Ack    = 1'b0;
    repeat (2) cyc();
    check("rst_busy", 32'(bus_if.Rec_Busy), 32'd0);
    check("rst_flush", 32'(bus_if.Global_Flush), 32'd0);
    check("rst_redir_pc", 32'(bus_if.Redirect_PC), 32'd0);
    check("rst_cnt", 32'(bus_if.Recovery_Cnt), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_busy", 32'(bus_if.Rec_Busy), 32'd0);

    // 1: immediate drain, ack in first REDIRECT cycle
    start_seq(16'h0040, 1'b1);
    check("t1_flush", 32'(bus_if.Global_Flush), 32'd1);
    check("t1_busy", 32'(bus_if.Rec_Busy), 32'd1);
    check("t1_pc", 32'(bus_if.Redirect_PC), 32'h0040);
    cyc();
    check("t1_flush_pulse", 32'(bus_if.Global_Flush), 32'd0);
    check("t1_drain_rat_v", 32'(bus_if.RAT_Restore_V), 32'd0);
    cyc();
    expect_restore("t1");
    bus_if.Redirect_Ack = 1'b1;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t1_idle_busy", 32'(bus_if.Rec_Busy), 32'd0);
    check("t1_idle_redir_v", 32'(bus_if.Redirect_V), 32'd0);
    check("t1_cnt", 32'(bus_if.Recovery_Cnt), 32'd1);
    $display("rec 1: pc=%h cnt=%0d", bus_if.Redirect_PC, bus_if.Recovery_Cnt);

    // 2: store buffer empties after 5 busy DRAIN cycles
    start_seq(16'h1234, 1'b0);
    check("t2_flush", 32'(bus_if.Global_Flush), 32'd1);
    drain_phase(6, dcyc, derr);
    check("t2_drain_cycles", 32'(dcyc), 32'd6);
    check("t2_drain_err", 32'(bus_if.Drain_Err), 32'd0);
    expect_restore("t2");
    bus_if.Redirect_Ack = 1'b1;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t2_cnt", 32'(bus_if.Recovery_Cnt), 32'd2);
    $display("rec 2: drain_cycles=%0d cnt=%0d", dcyc, bus_if.Recovery_Cnt);

    // 3: store buffer never empties -> timeout
    start_seq(16'h5A5A, 1'b0);
    drain_phase(0, dcyc, derr);
    check("t3_drain_cycles", 32'(dcyc), 32'd255);
    check("t3_err_early", 32'(derr), 32'd0);
    check("t3_drain_err", 32'(bus_if.Drain_Err), 32'd1);
    expect_restore("t3");
    check("t3_pc", 32'(bus_if.Redirect_PC), 32'h5A5A);
    bus_if.Redirect_Ack = 1'b1;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t3_err_sticky", 32'(bus_if.Drain_Err), 32'd1);
    check("t3_cnt", 32'(bus_if.Recovery_Cnt), 32'd3);
    $display("rec 3: drain_cycles=%0d drain_err=%0d cnt=%0d", dcyc, bus_if.Drain_Err, bus_if.Recovery_Cnt);

    // 4: ack delayed 7 cycles while head inputs toggle
    start_seq(16'h0040, 1'b1);
    cyc();
    cyc();
    expect_restore("t4");
    for (int k = 0; k < 7; k++) begin
      bus_if.Head_Mispred    = (k % 2 == 0);
      bus_if.Head_Correct_PC = 16'hBEEF;
      check("t4_redir_v", 32'(bus_if.Redirect_V), 32'd1);
      check("t4_pc_hold", 32'(bus_if.Redirect_PC), 32'h0040);
      check("t4_no_flush", 32'(bus_if.Global_Flush), 32'd0);
      if (k < 6) cyc();
    end
    bus_if.Head_Mispred = 1'b0;
    bus_if.Redirect_Ack = 1'b1;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t4_cnt", 32'(bus_if.Recovery_Cnt), 32'd4);
    cyc();
    check("t4_stay_idle", 32'(bus_if.Rec_Busy), 32'd0);
    check("t4_no_flush_after", 32'(bus_if.Global_Flush), 32'd0);
    $display("rec 4: pc=%h cnt=%0d", bus_if.Redirect_PC, bus_if.Recovery_Cnt);

    // 5: async reset during RESTORE at idx 3
    start_seq(16'h7777, 1'b1);
    cyc();
    cyc();
    repeat (3) cyc();
    check("t5_idx3", 32'(bus_if.RAT_Restore_Idx), 32'd3);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(bus_if.Rec_Busy), 32'd0);
    check("t5_rat_v", 32'(bus_if.RAT_Restore_V), 32'd0);
    check("t5_idx", 32'(bus_if.RAT_Restore_Idx), 32'd0);
    check("t5_redir_v", 32'(bus_if.Redirect_V), 32'd0);
    check("t5_pc", 32'(bus_if.Redirect_PC), 32'd0);
    check("t5_err", 32'(bus_if.Drain_Err), 32'd0);
    check("t5_cnt", 32'(bus_if.Recovery_Cnt), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("t5_idle", 32'(bus_if.Rec_Busy), 32'd0);
    $display("rec 5: reset abort cnt=%0d", bus_if.Recovery_Cnt);

    // 6: back-to-back recoveries
    start_seq(16'h0100, 1'b1);
    cyc();
    cyc();
    expect_restore("t6a");
    bus_if.Redirect_Ack    = 1'b1;
    bus_if.Head_Mispred    = 1'b1;
    bus_if.Head_Correct_PC = 16'h0200;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t6_idle_busy", 32'(bus_if.Rec_Busy), 32'd0);
    check("t6_cnt1", 32'(bus_if.Recovery_Cnt), 32'd1);
    cyc();
    bus_if.Head_Mispred = 1'b0;
    check("t6_flush2", 32'(bus_if.Global_Flush), 32'd1);
    check("t6_pc2", 32'(bus_if.Redirect_PC), 32'h0200);
    cyc();
    cyc();
    expect_restore("t6b");
    bus_if.Redirect_Ack = 1'b1;
    cyc();
    bus_if.Redirect_Ack = 1'b0;
    check("t6_cnt2", 32'(bus_if.Recovery_Cnt), 32'd2);
    $display("rec 6: pc=%h cnt=%0d", bus_if.Redirect_PC, bus_if.Recovery_Cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
